// File: rtl/weighted_majority_window.sv
// N-channel weighted voter with a DEPTH-sample sliding window; decision/tie/win_sum/fill register one edge after in_valid.
// No backpressure: every in_valid sample is taken unless a weight write flushes it. VOTE_HYST_EN enables the HYST margin rule.
module weighted_majority_window #(
  parameter int N     = 4,
  parameter int WW    = 4,
  parameter int DEPTH = 4,
  parameter int HYST  = 0,
  localparam int AW   = (N > 1) ? $clog2(N) : 1,
  localparam int FW   = $clog2(DEPTH + 1),
  localparam int WINW = WW + $clog2(N + 1) + $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [N-1:0]    in_bits,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [WW-1:0]   wr_data,
  output logic            vote_out,
  output logic            out_valid,
  output logic            tie,
  output logic [WINW-1:0] win_sum,
  output logic [FW-1:0]   fill
);

  localparam int SW = WW + $clog2(N + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = WINW + 2;

  logic [WW-1:0]   weight_q [N];
  logic [SW-1:0]   win_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [WINW-1:0] win_sum_q, win_sum_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic            vote_q, vote_d;
  logic            tie_q, tie_d;
  logic            out_valid_q;

  logic [SW-1:0]   total_w;
  logic [SW-1:0]   score;
  logic [WINW-1:0] eff;
  logic [WINW:0]   two_sum;
  logic            full;
  logic            wr_ok;
  logic            smp;

  always_comb begin
    total_w = '0;
    score   = '0;
    for (int i = 0; i < N; i++) begin
      total_w = total_w + SW'(weight_q[i]);
      if (in_bits[i]) score = score + SW'(weight_q[i]);
    end
  end

  // Out-of-range addresses behave exactly as if no write were requested.
  assign wr_ok = wr_en && (int'(wr_addr) < N);
  assign smp   = in_valid && !wr_ok;
  assign full  = (fill_q == FW'(DEPTH));

  always_comb begin
    win_sum_d = win_sum_q + WINW'(score) - (full ? WINW'(win_q[ptr_q]) : '0);
    fill_d    = full ? fill_q : fill_q + 1'b1;
    ptr_d     = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    eff       = WINW'(total_w) * WINW'(fill_d);
    two_sum   = {win_sum_d, 1'b0};
  end

`ifdef VOTE_HYST_EN
  logic signed [DW-1:0] margin;
  logic signed [DW-1:0] hyst_s;

  always_comb begin
    hyst_s = DW'(HYST);
    margin = $signed({1'b0, two_sum}) - $signed({2'b00, eff});
    vote_d = vote_q;
    if (margin > hyst_s)       vote_d = 1'b1;
    else if (margin < -hyst_s) vote_d = 1'b0;
    tie_d  = (margin == '0);
  end
`else
  always_comb begin
    vote_d = vote_q;
    tie_d  = 1'b0;
    if (two_sum > {1'b0, eff})      vote_d = 1'b1;
    else if (two_sum < {1'b0, eff}) vote_d = 1'b0;
    else                            tie_d  = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) weight_q[i] <= WW'(1);
      for (int j = 0; j < DEPTH; j++) win_q[j] <= '0;
      ptr_q       <= '0;
      win_sum_q   <= '0;
      fill_q      <= '0;
      vote_q      <= 1'b0;
      tie_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (wr_ok) begin
        for (int i = 0; i < N; i++)
          if (wr_addr == AW'(i)) weight_q[i] <= wr_data;
        for (int j = 0; j < DEPTH; j++) win_q[j] <= '0;
        ptr_q     <= '0;
        win_sum_q <= '0;
        fill_q    <= '0;
      end else if (smp) begin
        win_q[ptr_q] <= score;
        ptr_q        <= ptr_d;
        win_sum_q    <= win_sum_d;
        fill_q       <= fill_d;
        vote_q       <= vote_d;
        tie_q        <= tie_d;
        out_valid_q  <= 1'b1;
      end
    end
  end

  assign vote_out  = vote_q;
  assign out_valid = out_valid_q;
  assign tie       = tie_q;
  assign win_sum   = win_sum_q;
  assign fill      = fill_q;

endmodule
